// File: rtl/reglk_provisioner.sv
// Boot-time initiator that programs the reglk lock slots over the simple register bus.
// It writes one word per slot, can read each slot back to compare, and records mismatch and timeout per slot.
module reglk_provisioner #(
  parameter int unsigned                  NUM_SLOTS  = 6,
  parameter int unsigned                  ADDR_WIDTH = 64,
  parameter int unsigned                  DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0]        BASE_ADDR  = '0,
  parameter int unsigned                  TIMEOUT    = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic                            abort_i,
  input  logic                            verify_en_i,
  input  logic [32*NUM_SLOTS-1:0]         cfg_i,
  output logic                            req_o,
  output logic                            we_o,
  output logic [ADDR_WIDTH-1:0]           addr_o,
  output logic [DATA_WIDTH-1:0]           wdata_o,
  input  logic                            gnt_i,
  input  logic [DATA_WIDTH-1:0]           rdata_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [NUM_SLOTS-1:0]            err_o,
  output logic [NUM_SLOTS-1:0]            timeout_o
);

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, WR, RD, CHK, NEXT, DONE} state_e;

  state_e                   state_q;
  logic [SW-1:0]            slot_q;
  logic [CW-1:0]            wcnt_q;
  logic [32*NUM_SLOTS-1:0]  cfg_q;
  logic                     verify_q;
  logic [31:0]              rdat_q;
  logic                     req_q, we_q, busy_q, done_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [NUM_SLOTS-1:0]     err_q, to_q;

  // Only the low 32 bits of read data carry the lock word.
  logic unused_rdata;
  if (DATA_WIDTH > 32) begin : g_unused
    assign unused_rdata = ^rdata_i[DATA_WIDTH-1:32];
  end else begin : g_nounused
    assign unused_rdata = 1'b0;
  end

  function automatic logic [ADDR_WIDTH-1:0] slot_addr(input logic [SW-1:0] s);
    return BASE_ADDR + (ADDR_WIDTH'(s) << 3);
  endfunction

  function automatic logic [31:0] slot_word(input logic [32*NUM_SLOTS-1:0] c,
                                            input logic [SW-1:0] s);
    return c[int'(s)*32 +: 32];
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      wcnt_q   <= '0;
      cfg_q    <= '0;
      verify_q <= 1'b0;
      rdat_q   <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= '0;
      to_q     <= '0;
    end else if (abort_i && state_q != IDLE) begin
      // Status bits are kept so the abandoned run can still be inspected.
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && !abort_i) begin
            state_q  <= WR;
            cfg_q    <= cfg_i;
            verify_q <= verify_en_i;
            slot_q   <= '0;
            wcnt_q   <= '0;
            err_q    <= '0;
            to_q     <= '0;
            req_q    <= 1'b1;
            we_q     <= 1'b1;
            addr_q   <= slot_addr('0);
            wdata_q  <= DATA_WIDTH'(slot_word(cfg_i, '0));
            busy_q   <= 1'b1;
          end
        end
        WR, RD: begin
          if (gnt_i) begin
            wcnt_q  <= '0;
            wdata_q <= '0;
            if (state_q == WR && verify_q) begin
              state_q <= RD;
              we_q    <= 1'b0;
            end else begin
              state_q <= (state_q == RD) ? CHK : NEXT;
              req_q   <= 1'b0;
              we_q    <= 1'b0;
              addr_q  <= '0;
            end
            if (state_q == RD) rdat_q <= rdata_i[31:0];
          end else if (wcnt_q == CW'(TIMEOUT-1)) begin
            to_q[slot_q] <= 1'b1;
            state_q      <= NEXT;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        CHK: begin
          if (rdat_q != slot_word(cfg_q, slot_q)) err_q[slot_q] <= 1'b1;
          state_q <= NEXT;
        end
        NEXT: begin
          if (slot_q == SW'(NUM_SLOTS-1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= WR;
            slot_q  <= slot_q + 1'b1;
            wcnt_q  <= '0;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= slot_addr(slot_q + 1'b1);
            wdata_q <= DATA_WIDTH'(slot_word(cfg_q, slot_q + 1'b1));
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_o     = req_q;
  assign we_o      = we_q;
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign timeout_o = to_q;

endmodule

// File: tb/tb_reglk_provisioner.sv
// Directed bench for reglk_provisioner: bus responder model plus an ordered scoreboard of expected transactions.
module tb_reglk_provisioner;

  localparam logic [63:0] NONE = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, verify;
  logic [191:0] cfg;
  logic        req, we, gnt, busy, done;
  logic [63:0] addr, wdata, rdata;
  logic [5:0]  err, to;

  logic        start2;
  logic [63:0] cfg2;
  logic        req2, we2, busy2, done2;
  logic [63:0] addr2, wdata2;
  logic [1:0]  err2, to2;

  always #5 clk = ~clk;

  reglk_provisioner dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .verify_en_i(verify), .cfg_i(cfg), .req_o(req), .we_o(we),
    .addr_o(addr), .wdata_o(wdata), .gnt_i(gnt), .rdata_i(rdata),
    .busy_o(busy), .done_o(done), .err_o(err), .timeout_o(to)
  );

  reglk_provisioner #(.NUM_SLOTS(2), .BASE_ADDR(64'hFFFF_FFFF_FFFF_FFF8)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .abort_i(1'b0),
    .verify_en_i(1'b0), .cfg_i(cfg2), .req_o(req2), .we_o(we2),
    .addr_o(addr2), .wdata_o(wdata2), .gnt_i(req2), .rdata_i(64'h0),
    .busy_o(busy2), .done_o(done2), .err_o(err2), .timeout_o(to2)
  );

  // Responder: grants everything except the blocked write/read address.
  logic [63:0] blk_w = NONE, blk_r = NONE;
  int          lock_slot = -1;
  logic [31:0] mem [8] = '{default: 32'h0};

  assign gnt = req && !(we ? (addr == blk_w) : (addr == blk_r));

  always_comb begin
    rdata = {32'hDEAD_BEEF, mem[addr[5:3]]};
    if (lock_slot >= 0 && int'(addr[5:3]) == lock_slot) rdata[31:0] = 32'h0;
  end

  always @(posedge clk) if (req && gnt && we) mem[addr[5:3]] <= wdata[31:0];

  typedef struct { logic [63:0] addr; logic we; logic [63:0] data; } txn_t;
  txn_t sb[$];
  txn_t mt;

  int n_pass = 0, n_total = 0, done_cnt = 0, blk_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (done) done_cnt++;
    if (req && we && addr == blk_w) blk_cnt++;
    if (req && gnt) begin
      if (sb.size() == 0) check("sb_extra_txn", 64'd1, 64'd0);
      else begin
        mt = sb.pop_front();
        check("sb_addr", addr, mt.addr);
        check("sb_we", {63'd0, we}, {63'd0, mt.we});
        if (mt.we) check("sb_wdata", wdata, mt.data);
      end
    end
  end

  function automatic logic [31:0] word(input int k);
    return cfg[k*32 +: 32];
  endfunction

  task automatic push(input int k, input logic rd);
    sb.push_back('{addr: 64'(k*8), we: 1'b1, data: {32'h0, word(k)}});
    if (rd) sb.push_back('{addr: 64'(k*8), we: 1'b0, data: 64'h0});
  endtask

  task automatic start_seq(input logic v);
    @(negedge clk); verify = v; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 400) begin @(negedge clk); cyc++; end
    if (!done) check("done_seen", 64'd0, 64'd1);
  endtask

  int c, d0, w;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; verify = 1'b0; start2 = 1'b0;
    cfg2 = {32'h0000_0002, 32'h0000_0001};
    for (int k = 0; k < 6; k++) cfg[k*32 +: 32] = 32'hA0 + k;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_req",   {63'd0, req}, 64'd0);
    check("rst_we",    {63'd0, we}, 64'd0);
    check("rst_addr",  addr, 64'd0);
    check("rst_wdata", wdata, 64'd0);
    check("rst_busy",  {63'd0, busy}, 64'd0);
    check("rst_done",  {63'd0, done}, 64'd0);
    check("rst_err",   {58'd0, err}, 64'd0);
    check("rst_to",    {58'd0, to}, 64'd0);

    // 1: plain writes, zero-wait bus
    for (int k = 0; k < 6; k++) push(k, 1'b0);
    start_seq(1'b0);
    check("t1_req_rise", {63'd0, req}, 64'd1);
    check("t1_busy", {63'd0, busy}, 64'd1);
    wait_done(c);
    check("t1_latency", 64'(c), 64'd12);
    check("t1_busy_in_done", {63'd0, busy}, 64'd1);
    check("t1_err", {58'd0, err}, 64'd0);
    check("t1_to", {58'd0, to}, 64'd0);
    check("t1_sb_left", 64'(sb.size()), 64'd0);
    @(negedge clk);
    check("t1_done_pulse", {63'd0, done}, 64'd0);
    check("t1_busy_end", {63'd0, busy}, 64'd0);

    // 2: verify with slot 2 read-locked
    for (int k = 0; k < 6; k++) cfg[k*32 +: 32] = 32'h5A00_0000 | 32'((k+1)*32'h111);
    lock_slot = 2;
    for (int k = 0; k < 6; k++) push(k, 1'b1);
    d0 = done_cnt;
    start_seq(1'b1);
    wait_done(c);
    check("t2_latency", 64'(c), 64'd24);
    check("t2_err", {58'd0, err}, 64'b000100);
    check("t2_to", {58'd0, to}, 64'd0);
    repeat (3) @(negedge clk);
    check("t2_done_once", 64'(done_cnt - d0), 64'd1);
    check("t2_sb_left", 64'(sb.size()), 64'd0);
    lock_slot = -1;

    // 3: slot 4 never granted
    blk_w = 64'h20; blk_cnt = 0;
    for (int k = 0; k < 6; k++) if (k != 4) push(k, 1'b1);
    start_seq(1'b1);
    wait_done(c);
    check("t3_req_cycles", 64'(blk_cnt), 64'd16);
    check("t3_to", {58'd0, to}, 64'b010000);
    check("t3_err", {58'd0, err}, 64'd0);
    check("t3_sb_left", 64'(sb.size()), 64'd0);
    blk_w = NONE;

    // 4: abort while reading back slot 3, then restart
    blk_r = 64'h18; lock_slot = 1;
    for (int k = 0; k < 3; k++) push(k, 1'b1);
    push(3, 1'b0);
    start_seq(1'b1);
    w = 0;
    while (!(req && !we && addr == 64'h18) && w < 200) begin @(negedge clk); w++; end
    check("t4_reached_rd3", {63'd0, req && !we && addr == 64'h18}, 64'd1);
    d0 = done_cnt;
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("t4_req_drop", {63'd0, req}, 64'd0);
    check("t4_busy_drop", {63'd0, busy}, 64'd0);
    check("t4_err_kept", {58'd0, err}, 64'b000010);
    repeat (4) @(negedge clk);
    check("t4_no_done", 64'(done_cnt - d0), 64'd0);
    check("t4_sb_left", 64'(sb.size()), 64'd0);
    blk_r = NONE; lock_slot = -1;
    for (int k = 0; k < 6; k++) push(k, 1'b0);
    start_seq(1'b0);
    check("t4_err_clr", {58'd0, err}, 64'd0);
    check("t4_restart_addr", addr, 64'd0);
    wait_done(c);
    check("t4_sb_left2", 64'(sb.size()), 64'd0);

    // 5: reset during a stalled write, then a second start while busy
    blk_w = 64'h10;
    push(0, 1'b0); push(1, 1'b0);
    start_seq(1'b0);
    w = 0;
    while (!(req && addr == 64'h10) && w < 200) begin @(negedge clk); w++; end
    check("t5_stalled", {63'd0, req && addr == 64'h10}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("t5_rst_req", {63'd0, req}, 64'd0);
    check("t5_rst_addr", addr, 64'd0);
    check("t5_rst_wdata", wdata, 64'd0);
    check("t5_rst_busy", {63'd0, busy}, 64'd0);
    check("t5_rst_we", {63'd0, we}, 64'd0);
    check("t5_sb_left", 64'(sb.size()), 64'd0);
    blk_w = NONE;
    for (int k = 0; k < 6; k++) push(k, 1'b0);
    d0 = done_cnt;
    start_seq(1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(c);
    repeat (3) @(negedge clk);
    check("t5_done_once", 64'(done_cnt - d0), 64'd1);
    check("t5_idle_req", {63'd0, req}, 64'd0);
    check("t5_sb_left2", 64'(sb.size()), 64'd0);

    // 6: address wrap on the two-slot instance
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    check("t6_addr0", addr2, 64'hFFFF_FFFF_FFFF_FFF8);
    check("t6_wdata0", wdata2, 64'h1);
    @(negedge clk);
    check("t6_next_req", {63'd0, req2}, 64'd0);
    @(negedge clk);
    check("t6_addr1_wrap", addr2, 64'h0);
    check("t6_wdata1", wdata2, 64'h2);
    @(negedge clk); @(negedge clk);
    check("t6_done", {63'd0, done2}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reglk_provisioner.md
# reglk_provisioner

Boot-time initiator that programs the register-lock (reglk) slots over the simple register bus (enable / write-enable / address / data) that the reglk slave serves. On a start pulse it writes one 32-bit lock word per slot at base + 8·slot, optionally reads each slot back and compares, and reports per-slot mismatch and timeout status. It sits between the boot/secure-config logic and the reglk register block, ahead of any software access.

## Interface

- NUM_SLOTS, 6, number of 32-bit lock slots to program (1..32)
- ADDR_WIDTH, 64, bus address width
- DATA_WIDTH, 64, bus data width (≥32)
- BASE_ADDR, 0, address of slot 0; slot k at BASE_ADDR + 8·k
- TIMEOUT, 16, cycles a request may wait for grant before abandonment (≥2)

Reset: one clock; reset is synchronous and active-low.

- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- start_i  in  1  start pulse; ignored while busy_o=1
- abort_i  in  1  abandon sequence; highest priority after reset
- verify_en_i  in  1  enable read-back check; sampled with start_i
- cfg_i  in  32·NUM_SLOTS  lock words; slot k = cfg_i[32k+:32]; sampled with start_i
- req_o  out  1  bus request (maps to en)
- we_o  out  1  1 = write, 0 = read
- addr_o  out  ADDR_WIDTH  request address
- wdata_o  out  DATA_WIDTH  {zeros, slot word}
- gnt_i  in  1  responder accepts current request this cycle
- rdata_i  in  DATA_WIDTH  read data, valid when gnt_i=1 with we_o=0
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse at normal completion
- err_o  out  NUM_SLOTS  sticky read-back mismatch per slot
- timeout_o  out  NUM_SLOTS  sticky grant timeout per slot

## Operation

- States: IDLE, WR, RD, CHK, NEXT, DONE.
- IDLE: start_i=1 → latch cfg_i and verify_en_i, clear slot index, err_o, timeout_o, and wait counter → WR.
- WR: req_o=1, we_o=1, addr_o=BASE_ADDR+8·slot, wdata_o={0, cfg[slot]}. On gnt_i: go to RD if verify latched, else NEXT.
- RD: req_o=1, we_o=0, same addr_o. On gnt_i, capture rdata_i[31:0] → CHK.
- CHK: no request. If captured ≠ cfg[slot], set err_o[slot]. Go to NEXT.
- NEXT: if slot = NUM_SLOTS−1, go to DONE; else increment slot, clear wait counter, and go to WR.
- DONE: done_o=1 for this cycle → IDLE.
- Timeout: in WR/RD the wait counter increments each cycle without gnt_i. When the counter reaches TIMEOUT−1 with no gnt_i, set timeout_o[slot], drop req_o next cycle, and go to NEXT. Read-back is skipped and err_o[slot] is not set.
- abort_i=1 in any non-IDLE state → IDLE next cycle. No done_o. err_o and timeout_o hold their values.
- start_i while busy is ignored. start_i and abort_i together in IDLE: abort wins, stay IDLE.
- Outputs addr_o, wdata_o, and we_o are registered. addr_o/wdata_o hold stable while req_o=1 and are 0 when req_o=0.
- Address arithmetic is modulo 2^ADDR_WIDTH.
- The upper DATA_WIDTH−32 bits of rdata_i are ignored.

## Timing

- Reset values: req_o=0, we_o=0, addr_o=0, wdata_o=0, busy_o=0, done_o=0, err_o=0, timeout_o=0; state IDLE. Reset mid-sequence behaves the same, with no bus request in the cycle after reset.
- Start sampled at edge N: req_o rises at N+1. busy_o=1 from N+1 through the DONE cycle inclusive.
- A grant completes in the cycle gnt_i=1 with req_o=1. req_o changes value or drops on the following cycle.
- Zero-wait bus timing:
  - Without verify: 2 cycles per slot (WR, NEXT), so 12 cycles for 6 slots.
  - With verify: 4 cycles per slot (WR, RD, CHK, NEXT), so 24 cycles.
  - done_o follows one cycle after the last NEXT.
- Timed-out request: req_o is high for exactly TIMEOUT cycles.
- gnt_i while req_o=0 is ignored.

## Test plan

- No verify, always-grant responder, cfg slot k = 0xA0+k: six writes to addresses 0x00, 0x08, …, 0x28 with wdata 0xA0..0xA5. done_o is pulsed 13 cycles after the start edge. err_o = timeout_o = 0.
- Verify on, responder model stores writes but returns 0 for slot 2 (read-locked): err_o = 6'b000100, timeout_o = 0, done_o pulses once. Reads return cfg values for all other slots.
- Responder never grants slot 4, TIMEOUT=16: for slot 4, req_o is high exactly 16 cycles, then timeout_o = 6'b010000. Slot 5 is still written, done_o is asserted, and err_o[4] = 0.
- abort_i asserted while in RD of slot 3: req_o = 0 and busy_o = 0 next cycle, no done_o. err_o from slots 0–2 is retained. A new start_i then clears err_o/timeout_o and reprograms from slot 0.
- rst_ni low for 1 cycle mid-WR with gnt_i stalled: all outputs are at reset values on the following cycle. start_i during busy (second pulse) causes no restart and no extra writes.
- BASE_ADDR = 0xFFFF_FFFF_FFFF_FFF8 with NUM_SLOTS=2: slot 1 addr_o wraps to 0x0.
